// File: rtl/signal_router_fifo_pkg.sv
// ----------------------------------------------------------------------------
// router_pkg
// Shared definitions for signal_router_fifo and its per-channel FIFO.
//   DROP_CNT_W  : width of the saturating dropped-beat counter
//   occ_width() : occupancy counter width for a given FIFO depth
//   is_pow2()   : legality check for the FIFO depth
//   dest_fits() : legality check for NUM_OUT against the address width
// ----------------------------------------------------------------------------
package router_pkg;

  localparam int DROP_CNT_W = 16;

  // One extra bit so a full FIFO (count == DEPTH) is representable.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit dest_fits(input int num_out, input int addr_w);
    return (num_out >= 2) && (num_out <= 16) && (num_out <= (1 << addr_w));
  endfunction

endpackage

// File: rtl/signal_router_fifo_if.sv
// ----------------------------------------------------------------------------
// signal_router_fifo_if
// Handshake bundle around the router.
//   in_valid/in_ready/in_data/in_dest : single input stream with destination
//   out_valid/out_ready/out_data      : NUM_OUT output streams, channel k in
//                                       out_data[k*DATA_W +: DATA_W]
// Modports:
//   master : the side feeding the input stream and consuming the outputs
//   slave  : the router itself
// ----------------------------------------------------------------------------
interface signal_router_fifo_if #(
  parameter int DATA_W  = 16,
  parameter int NUM_OUT = 4,
  parameter int ADDR_W  = 3
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         in_data;
  logic [ADDR_W-1:0]         in_dest;
  logic [NUM_OUT-1:0]        out_valid;
  logic [NUM_OUT-1:0]        out_ready;
  logic [NUM_OUT*DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, in_dest, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_dest, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/signal_router_fifo_chan.sv
// ----------------------------------------------------------------------------
// router_chan_fifo
// Single-clock FIFO, DATA_W x DEPTH, one per output channel.
//   clk, rst : clock, asynchronous active-low reset (empties the FIFO)
//   push     : write din (ignored when full)
//   pop      : drop the head entry (ignored when empty)
//   full     : count == DEPTH
//   empty    : count == 0
//   head     : oldest entry, forced to 0 while empty
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module router_chan_fifo
  import router_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = occ_width(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; the cleared count
  // masks stale entries, and leaving it reset-free lets it map to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/signal_router_fifo.sv
// ----------------------------------------------------------------------------
// signal_router_fifo
// Steers one valid/ready stream into NUM_OUT buffered output channels by the
// per-beat destination address. Out-of-range destinations are accepted and
// discarded.
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   bus      : signal_router_fifo_if.slave (input stream + output channels)
//   drop_cnt : 16-bit saturating dropped-beat count, only when the macro
//              ROUTER_DROP_CNT_EN is defined
// The interface instance must use the same DATA_W/NUM_OUT/ADDR_W as this
// module.
// ----------------------------------------------------------------------------
module signal_router_fifo
  import router_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int NUM_OUT = 4,
  parameter int ADDR_W  = 3,
  parameter int DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  signal_router_fifo_if.slave   bus
`ifdef ROUTER_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  if (!dest_fits(NUM_OUT, ADDR_W)) begin : g_bad_num_out
    $error("signal_router_fifo: NUM_OUT must be 2..16 and <= 2**ADDR_W");
  end
  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("signal_router_fifo: DEPTH must be a power of two >= 2");
  end

  logic [NUM_OUT-1:0] push;
  logic [NUM_OUT-1:0] pop;
  logic [NUM_OUT-1:0] full;
  logic [NUM_OUT-1:0] empty;
  logic [DATA_W-1:0]  head [NUM_OUT];
  logic               dest_ok;
  logic               sel_full;
  logic               ready;

  // in_ready looks only at the registered full flag of the addressed
  // channel, so a stalled consumer never reaches the input handshake
  // combinationally and never blocks beats for other channels.
  // NOTE: every variable gets a default at the top of always_comb so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    dest_ok  = (int'(bus.in_dest) < NUM_OUT);
    sel_full = 1'b0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (bus.in_dest == ADDR_W'(k)) sel_full = full[k];
    end
    ready = rst && (!dest_ok || !sel_full);
    push  = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      push[k] = bus.in_valid && ready && (bus.in_dest == ADDR_W'(k));
    end
  end

  assign bus.in_ready  = ready;
  assign pop           = ~empty & bus.out_ready;
  assign bus.out_valid = ~empty;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_chan
    router_chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[k]),
      .pop   (pop[k]),
      .din   (bus.in_data),
      .full  (full[k]),
      .empty (empty[k]),
      .head  (head[k])
    );
  end

  always_comb begin
    bus.out_data = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      bus.out_data[k*DATA_W +: DATA_W] = head[k];
    end
  end

`ifdef ROUTER_DROP_CNT_EN
  logic drop;

  assign drop = bus.in_valid && ready && !dest_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule
